multi_bbox_tracker: RTL and testbench
=====================================

Name: multi_bbox_tracker

Overview:
Per-channel bounding-box tracker for the vision pipeline. Taps the post-threshold pixel stream and takes a NUM_CH-bit detect vector, one bit per colour class. Accumulates per-channel min/max coordinates and pixel counts each frame. Every MSG_INTERVAL frames it writes a message for each qualifying channel into an internal FIFO, which the CPU drains over the Avalon-MM slave.

Parameters:
NUM_CH, 4, number of detect channels (1..16)
IMAGE_W, 640, pixels per line
IMAGE_H, 480, lines per frame
COORD_W, 11, coordinate width (<=16)
CNT_W, 19, per-channel pixel counter width, saturating
FIFO_DEPTH, 64, message FIFO words (power of 2, >= 3*NUM_CH)
MSG_INTERVAL, 6, frames between message bursts
MIN_PIX_DEFAULT, 16, reset value of the minimum-pixel threshold

Ports:
clk  in  1  clock
reset_n  in  1  reset, synchronous, active-low
in_valid  in  1  stream beat valid (observation tap, no backpressure)
in_sop  in  1  start of packet; the beat is a descriptor, not a pixel
in_eop  in  1  end of packet; the beat is the last pixel
in_video  in  1  packet-type flag, sampled on the sop beat
in_detect  in  NUM_CH  per-channel detect for the current beat
s_chipselect, s_read, s_write  in  1  MM slave controls
s_address  in  3  MM word address
s_writedata  in  32  MM write data
s_readdata  out  32  MM read data, registered
frame_done  out  1  one-cycle pulse when a snapshot loads
msg_pending  out  1  FIFO not empty

Behaviour:
- Reset state: all outputs 0; FIFO empty; FSM IDLE; frame_cnt = 0; min_pix = MIN_PIX_DEFAULT; ch_en = all ones.
- Coordinate counter:
  - On a sop beat: x,y <= 0; video <= in_video; detect is ignored.
  - On a non-sop valid beat with video = 1: x++; at x = IMAGE_W-1, x <= 0 and y++.
  - y is not range-checked.
- Accumulators, per channel c:
  - On a sop beat: xmin <= IMAGE_W-1, ymin <= IMAGE_H-1, xmax, ymax, cnt <= 0.
  - On a pixel beat with in_detect[c] = 1: update min/max; cnt increments and saturates at all-ones.
- Frame end:
  - Condition: eop pixel beat at cycle N with video = 1.
  - At N+1 (accumulators then include the eop pixel): if FSM is IDLE, snapshot <= accumulators, frame_done = 1, frame_cnt updates.
  - If FSM is not IDLE, the frame is dropped: no snapshot, no pulse, frame_cnt unchanged.
  - Non-video packets never touch the accumulators or the snapshot.
- Trigger, evaluated at snapshot load:
  - Fires if frame_cnt = 0 and FIFO free space >= 3*NUM_CH. Then frame_cnt <= MSG_INTERVAL-1, ch <= 0, FSM -> SCAN.
  - Else if frame_cnt = 0: hold at 0 and retry next frame.
  - Else: frame_cnt--.
- Message FSM (one state per cycle):
  - IDLE: wait for trigger.
  - SCAN: if ch_en[ch] and snap_cnt[ch] >= min_pix -> HDR. Else if ch = NUM_CH-1 -> IDLE. Else ch++.
  - HDR writes {8'h42, 8'(ch), sat16(snap_cnt)}.
  - TL writes {zero-ext16 xmin, zero-ext16 ymin}.
  - BR writes {zero-ext16 xmax, zero-ext16 ymax}.
  - After BR: if ch = NUM_CH-1 -> IDLE, else ch++ and -> SCAN.
  - With min_pix = 0, an empty channel still emits its message, with xmin=IMAGE_W-1, ymin=IMAGE_H-1, xmax=ymax=0.
- FIFO:
  - First-word-fall-through; usedw has log2(FIFO_DEPTH)+1 bits.
  - Writes cannot overflow because of the trigger space check.
  - Simultaneous pop and write: usedw unchanged.
- MM map (registered read, 1-cycle latency):
  - 0 STATUS: read {8'b0, 16'(usedw), 3'b0, 0, 3'b0, busy}. A write with bit4 = 1 flushes the FIFO and forces the FSM to IDLE; a flush wins over a same-cycle FSM write or pop.
  - 1 READ_MSG: read returns the FIFO head, or 0 when empty. Pop occurs only on the first cycle of a read (s_read & ~read_d) and only when not empty.
  - 2 ID: reads 32'h1234EEE3.
  - 3 MIN_PIX: rw, CNT_W bits.
  - 4 CH_EN: rw, NUM_CH bits.
  - Other addresses: read 0, writes ignored.
- Reset mid-frame: state is cleared. The next sop restarts cleanly; stream beats before that sop are counted from x=y=0 with video = 0, so they are ignored.

Test Plan:
- 640x480 video frame, ch0 detect on pixels (10..20, 5..7), MSG_INTERVAL=1 -> frame_done at eop+1. FIFO holds 3 words: 0x42000021, 0x000A0005, 0x00140007. usedw = 3.
- ch1 with 15 pixels, min_pix = 16 -> no ch1 words. Write MIN_PIX = 15, next frame -> ch1 message with count 0x000F.
- MSG_INTERVAL=6 over 12 frames, FIFO drained each frame -> bursts after frames 1 and 7 only.
- Fill the FIFO to FIFO_DEPTH-2 with NUM_CH = 4 -> no burst, frame_cnt holds at 0. Pop 10 words, next frame -> burst.
- Non-video packet (in_video = 0) between frames with detects asserted -> snapshot and messages unchanged.
- Flush written during a burst -> usedw = 0, busy = 0 next cycle. A 2-cycle s_read on READ_MSG pops exactly one word; a read when empty returns 0.

Source files
------------

// File: rtl/multi_bbox_tracker.sv
// Per-channel bounding-box tracker: accumulates min/max/count per detect channel
// over each video frame and periodically queues messages for CPU readout.
module multi_bbox_tracker #(
    parameter int NUM_CH          = 4,
    parameter int IMAGE_W         = 640,
    parameter int IMAGE_H         = 480,
    parameter int COORD_W         = 11,
    parameter int CNT_W           = 19,
    parameter int FIFO_DEPTH      = 64,
    parameter int MSG_INTERVAL    = 6,
    parameter int MIN_PIX_DEFAULT = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic              in_sop,
    input  logic              in_eop,
    input  logic              in_video,
    input  logic [NUM_CH-1:0] in_detect,
    input  logic              s_chipselect,
    input  logic              s_read,
    input  logic              s_write,
    input  logic [2:0]        s_address,
    input  logic [31:0]       s_writedata,
    output logic [31:0]       s_readdata,
    output logic              frame_done,
    output logic              msg_pending
);
    localparam int AW        = $clog2(FIFO_DEPTH);
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int FC_W      = (MSG_INTERVAL > 1) ? $clog2(MSG_INTERVAL) : 1;
    localparam int MSG_WORDS = 3 * NUM_CH;

    localparam logic [2:0] ADDR_STATUS = 3'd0;
    localparam logic [2:0] ADDR_MSG    = 3'd1;
    localparam logic [2:0] ADDR_ID     = 3'd2;
    localparam logic [2:0] ADDR_MINPIX = 3'd3;
    localparam logic [2:0] ADDR_CHEN   = 3'd4;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [CNT_W-1:0]   cnt_t;
    typedef enum logic [2:0] {IDLE, SCAN, HDR, TL, BR} state_t;

    localparam coord_t          X_LAST  = coord_t'(IMAGE_W - 1);
    localparam coord_t          Y_LAST  = coord_t'(IMAGE_H - 1);
    localparam logic [CH_W-1:0] CH_LAST = CH_W'(NUM_CH - 1);

    function automatic logic [15:0] sat16(input cnt_t v);
        if (32'(v) > 32'h0000_FFFF) return 16'hFFFF;
        return 16'(v);
    endfunction

    // ---------------- stream coordinate tracking ----------------
    coord_t x, y;
    logic   video, eop_d;
    logic   sop_beat, pix_beat;

    assign sop_beat = in_valid & in_sop;
    assign pix_beat = in_valid & ~in_sop & video;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            x     <= '0;
            y     <= '0;
            video <= 1'b0;
            eop_d <= 1'b0;
        end else begin
            eop_d <= pix_beat & in_eop;
            if (sop_beat) begin
                x     <= '0;
                y     <= '0;
                video <= in_video;
            end else if (pix_beat) begin
                if (x == X_LAST) begin
                    x <= '0;
                    y <= y + coord_t'(1);
                end else begin
                    x <= x + coord_t'(1);
                end
            end
        end
    end

    // ---------------- per-channel accumulators ----------------
    coord_t xmin [NUM_CH];
    coord_t ymin [NUM_CH];
    coord_t xmax [NUM_CH];
    coord_t ymax [NUM_CH];
    cnt_t   cnt  [NUM_CH];

    // Only a video sop clears them, so non-video packets leave them alone.
    always_ff @(posedge clk) begin
        if (!reset_n || (sop_beat && in_video)) begin
            for (int c = 0; c < NUM_CH; c++) begin
                xmin[c] <= X_LAST;
                ymin[c] <= Y_LAST;
                xmax[c] <= '0;
                ymax[c] <= '0;
                cnt[c]  <= '0;
            end
        end else if (pix_beat) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (in_detect[c]) begin
                    if (x < xmin[c]) xmin[c] <= x;
                    if (y < ymin[c]) ymin[c] <= y;
                    if (x > xmax[c]) xmax[c] <= x;
                    if (y > ymax[c]) ymax[c] <= y;
                    if (cnt[c] != '1) cnt[c] <= cnt[c] + cnt_t'(1);
                end
            end
        end
    end

    // ---------------- snapshot and burst trigger ----------------
    state_t          state, state_nx;
    logic [CH_W-1:0] ch, ch_nx;
    logic [AW:0]     usedw;
    logic [FC_W-1:0] frame_cnt;
    logic            snap_load, fifo_room, trigger, flush;

    coord_t snap_xmin [NUM_CH];
    coord_t snap_ymin [NUM_CH];
    coord_t snap_xmax [NUM_CH];
    coord_t snap_ymax [NUM_CH];
    cnt_t   snap_cnt  [NUM_CH];

    assign snap_load  = eop_d & (state == IDLE);
    assign frame_done = snap_load;
    assign fifo_room  = usedw <= (AW+1)'(FIFO_DEPTH - MSG_WORDS);
    assign trigger    = snap_load & (frame_cnt == '0) & fifo_room;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                snap_xmin[c] <= '0;
                snap_ymin[c] <= '0;
                snap_xmax[c] <= '0;
                snap_ymax[c] <= '0;
                snap_cnt[c]  <= '0;
            end
            frame_cnt <= '0;
        end else if (snap_load) begin
            snap_xmin <= xmin;
            snap_ymin <= ymin;
            snap_xmax <= xmax;
            snap_ymax <= ymax;
            snap_cnt  <= cnt;
            if (frame_cnt != '0)
                frame_cnt <= frame_cnt - FC_W'(1);
            else if (fifo_room)
                frame_cnt <= FC_W'(MSG_INTERVAL - 1);
        end
    end

    // ---------------- message FSM ----------------
    cnt_t              min_pix;
    logic [NUM_CH-1:0] ch_en;
    logic              fifo_wr;
    logic [31:0]       fifo_wdata;

    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            state <= IDLE;
            ch    <= '0;
        end else begin
            state <= state_nx;
            ch    <= ch_nx;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a variable unassigned and infer a latch.
    always_comb begin
        state_nx   = state;
        ch_nx      = ch;
        fifo_wr    = 1'b0;
        fifo_wdata = '0;
        unique case (state)
            IDLE: if (trigger) begin
                state_nx = SCAN;
                ch_nx    = '0;
            end
            SCAN: begin
                if (ch_en[ch] && snap_cnt[ch] >= min_pix) state_nx = HDR;
                else if (ch == CH_LAST)                    state_nx = IDLE;
                else                                       ch_nx    = ch + CH_W'(1);
            end
            HDR: begin
                fifo_wr    = 1'b1;
                fifo_wdata = {8'h42, 8'(ch), sat16(snap_cnt[ch])};
                state_nx   = TL;
            end
            TL: begin
                fifo_wr    = 1'b1;
                fifo_wdata = {16'(snap_xmin[ch]), 16'(snap_ymin[ch])};
                state_nx   = BR;
            end
            BR: begin
                fifo_wr    = 1'b1;
                fifo_wdata = {16'(snap_xmax[ch]), 16'(snap_ymax[ch])};
                if (ch == CH_LAST) begin
                    state_nx = IDLE;
                end else begin
                    state_nx = SCAN;
                    ch_nx    = ch + CH_W'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // ---------------- message FIFO (first-word-fall-through) ----------------
    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          push, pop, rd, wr, read_d, rd_first;

    assign rd       = s_chipselect & s_read;
    assign wr       = s_chipselect & s_write;
    assign rd_first = rd & ~read_d;
    assign flush    = wr & (s_address == ADDR_STATUS) & s_writedata[4];
    assign push     = fifo_wr & ~flush;
    assign pop      = rd_first & (s_address == ADDR_MSG) & (usedw != '0) & ~flush;

    // NOTE: the storage array is deliberately not reset; pointers and usedw
    // alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= fifo_wdata;
    end

    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            usedw  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      usedw <= usedw + (AW+1)'(1);
            else if (pop && !push) usedw <= usedw - (AW+1)'(1);
        end
    end

    assign msg_pending = (usedw != '0);

    // ---------------- Avalon-MM slave ----------------
    logic [31:0] rdata_mux;
    logic        busy;
    logic        unused_bits;

    assign busy        = (state != IDLE);
    assign unused_bits = &{1'b0, s_writedata};

    always_comb begin
        rdata_mux = '0;
        case (s_address)
            ADDR_STATUS: rdata_mux = {8'b0, 16'(usedw), 7'b0, busy};
            ADDR_MSG:    if (usedw != '0) rdata_mux = mem[rd_ptr];
            ADDR_ID:     rdata_mux = 32'h1234EEE3;
            ADDR_MINPIX: rdata_mux = 32'(min_pix);
            ADDR_CHEN:   rdata_mux = 32'(ch_en);
            default:     rdata_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            min_pix    <= cnt_t'(MIN_PIX_DEFAULT);
            ch_en      <= '1;
            read_d     <= 1'b0;
            s_readdata <= '0;
        end else begin
            read_d <= rd;
            if (wr && s_address == ADDR_MINPIX) min_pix <= s_writedata[CNT_W-1:0];
            if (wr && s_address == ADDR_CHEN)   ch_en   <= s_writedata[NUM_CH-1:0];
            if (rd) s_readdata <= rdata_mux;
        end
    end

endmodule

// File: tb/tb_multi_bbox_tracker.sv
// Self-checking bench for multi_bbox_tracker: a bench-side model pushes expected
// message words to a queue, which is compared against words read over Avalon-MM.
module tb_multi_bbox_tracker;
    localparam int NUM_CH          = 4;
    localparam int IMAGE_W         = 32;
    localparam int IMAGE_H         = 10;
    localparam int COORD_W         = 11;
    localparam int CNT_W           = 19;
    localparam int FIFO_DEPTH      = 16;
    localparam int MSG_INTERVAL    = 6;
    localparam int MIN_PIX_DEFAULT = 16;

    localparam logic [2:0] A_STATUS = 3'd0;
    localparam logic [2:0] A_MSG    = 3'd1;
    localparam logic [2:0] A_ID     = 3'd2;
    localparam logic [2:0] A_MINPIX = 3'd3;
    localparam logic [2:0] A_CHEN   = 3'd4;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0, in_video = 1'b0;
    logic [NUM_CH-1:0] in_detect = '0;
    logic              s_chipselect = 1'b0, s_read = 1'b0, s_write = 1'b0;
    logic [2:0]        s_address = '0;
    logic [31:0]       s_writedata = '0;
    logic [31:0]       s_readdata;
    logic              frame_done, msg_pending;

    always #5 clk = ~clk;

    multi_bbox_tracker #(
        .NUM_CH(NUM_CH), .IMAGE_W(IMAGE_W), .IMAGE_H(IMAGE_H), .COORD_W(COORD_W),
        .CNT_W(CNT_W), .FIFO_DEPTH(FIFO_DEPTH), .MSG_INTERVAL(MSG_INTERVAL),
        .MIN_PIX_DEFAULT(MIN_PIX_DEFAULT)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop), .in_video(in_video),
        .in_detect(in_detect),
        .s_chipselect(s_chipselect), .s_read(s_read), .s_write(s_write),
        .s_address(s_address), .s_writedata(s_writedata), .s_readdata(s_readdata),
        .frame_done(frame_done), .msg_pending(msg_pending)
    );

    int total = 0;
    int bad   = 0;
    int fd_count = 0;
    logic last_fd;

    // Reference model state
    int                m_fc, m_used, m_min_pix;
    logic [NUM_CH-1:0] m_ch_en;
    logic [31:0]       exp_q[$];
    int                r_on[NUM_CH], rx0[NUM_CH], rx1[NUM_CH], ry0[NUM_CH], ry1[NUM_CH];

    always @(negedge clk) if (frame_done === 1'b1) fd_count++;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0; in_valid = 0; in_sop = 0; in_eop = 0; in_video = 0; in_detect = '0;
        s_chipselect = 0; s_read = 0; s_write = 0; s_address = '0; s_writedata = '0;
        tick(3);
        reset_n = 1'b1;
        tick(1);
        m_fc = 0; m_used = 0; m_min_pix = MIN_PIX_DEFAULT; m_ch_en = '1;
        exp_q.delete();
        for (int c = 0; c < NUM_CH; c++) r_on[c] = 0;
    endtask

    task automatic set_rect(input int c, input int x0, input int x1, input int y0, input int y1);
        r_on[c] = 1; rx0[c] = x0; rx1[c] = x1; ry0[c] = y0; ry1[c] = y1;
    endtask

    function automatic logic [NUM_CH-1:0] det_at(input int x, input int y);
        det_at = '0;
        for (int c = 0; c < NUM_CH; c++)
            if (r_on[c] != 0 && x >= rx0[c] && x <= rx1[c] && y >= ry0[c] && y <= ry1[c])
                det_at[c] = 1'b1;
    endfunction

    task automatic mm_write(input logic [2:0] addr, input logic [31:0] data);
        @(negedge clk);
        s_chipselect = 1; s_write = 1; s_address = addr; s_writedata = data;
        @(negedge clk);
        s_chipselect = 0; s_write = 0;
        if (addr == A_MINPIX) m_min_pix = int'(data[CNT_W-1:0]);
        if (addr == A_CHEN)   m_ch_en = data[NUM_CH-1:0];
    endtask

    task automatic mm_read(input logic [2:0] addr, output logic [31:0] data);
        @(negedge clk);
        s_chipselect = 1; s_read = 1; s_address = addr;
        @(negedge clk);
        s_chipselect = 0; s_read = 0;
        data = s_readdata;
    endtask

    // Model of frame end: trigger decision and message words for the finished frame.
    task automatic model_frame_end();
        int cnt_c, xmn, ymn, xmx, ymx;
        if (m_fc == 0) begin
            if (FIFO_DEPTH - m_used >= 3 * NUM_CH) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (r_on[c] != 0) begin
                        cnt_c = (rx1[c] - rx0[c] + 1) * (ry1[c] - ry0[c] + 1);
                        xmn = rx0[c]; ymn = ry0[c]; xmx = rx1[c]; ymx = ry1[c];
                    end else begin
                        cnt_c = 0; xmn = IMAGE_W - 1; ymn = IMAGE_H - 1; xmx = 0; ymx = 0;
                    end
                    if (m_ch_en[c] && cnt_c >= m_min_pix) begin
                        exp_q.push_back({8'h42, 8'(c), 16'(cnt_c)});
                        exp_q.push_back({16'(xmn), 16'(ymn)});
                        exp_q.push_back({16'(xmx), 16'(ymx)});
                        m_used += 3;
                    end
                end
                m_fc = MSG_INTERVAL - 1;
            end
        end else begin
            m_fc--;
        end
    endtask

    task automatic send_frame(input bit video, input bit all_det);
        @(negedge clk);
        in_valid = 1; in_sop = 1; in_eop = 0; in_video = video; in_detect = NUM_CH'($urandom);
        for (int y = 0; y < IMAGE_H; y++) begin
            for (int x = 0; x < IMAGE_W; x++) begin
                if ($urandom_range(0, 9) == 0) begin
                    @(negedge clk);
                    in_valid = 0; in_sop = 0; in_eop = 0; in_detect = NUM_CH'($urandom);
                end
                @(negedge clk);
                in_valid = 1; in_sop = 0; in_video = 1'($urandom);
                in_eop = (x == IMAGE_W - 1 && y == IMAGE_H - 1);
                in_detect = all_det ? '1 : det_at(x, y);
            end
        end
        @(negedge clk);
        in_valid = 0; in_eop = 0; in_detect = '0;
        last_fd = frame_done;
        if (video) model_frame_end();
    endtask

    task automatic wait_burst();
        tick(40);
    endtask

    task automatic check_status(input string name);
        logic [31:0] d;
        mm_read(A_STATUS, d);
        total++;
        if (d !== {8'b0, 16'(m_used), 8'b0}) begin
            bad++;
            $display("FAIL %s status: got %h expected %h", name, d, {8'b0, 16'(m_used), 8'b0});
        end
    endtask

    task automatic drain(input string name, input int n);
        logic [31:0] d, e;
        for (int i = 0; i < n; i++) begin
            mm_read(A_MSG, d);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'h0;
            if (m_used > 0) m_used--;
            total++;
            if (d !== e) begin
                bad++;
                $display("FAIL %s word%0d: got %h expected %h", name, i, d, e);
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        do_reset();
        total++; if (s_readdata !== 32'h0) begin bad++; $display("FAIL reset_readdata: got %h expected 0", s_readdata); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
        total++; if (msg_pending !== 1'b0) begin bad++; $display("FAIL reset_msg_pending: got %b expected 0", msg_pending); end
        check_status("reset");
        mm_read(A_ID, d);
        total++; if (d !== 32'h1234EEE3) begin bad++; $display("FAIL id: got %h expected 1234eee3", d); end
        mm_read(A_MINPIX, d);
        total++; if (d !== 32'(MIN_PIX_DEFAULT)) begin bad++; $display("FAIL min_pix_reset: got %h expected %h", d, 32'(MIN_PIX_DEFAULT)); end
        mm_read(A_CHEN, d);
        total++; if (d !== 32'hF) begin bad++; $display("FAIL ch_en_reset: got %h expected f", d); end
        mm_read(3'd6, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL unmapped: got %h expected 0", d); end
        drain("reset_empty", 1);
    endtask

    task automatic test_basic();
        do_reset();
        set_rect(0, 10, 20, 5, 7);
        send_frame(1, 0);
        total++; if (last_fd !== 1'b1) begin bad++; $display("FAIL basic_frame_done: got %b expected 1", last_fd); end
        wait_burst();
        total++; if (msg_pending !== 1'b1) begin bad++; $display("FAIL basic_pending: got %b expected 1", msg_pending); end
        check_status("basic_full");
        drain("basic", m_used);
        check_status("basic_empty");
    endtask

    task automatic test_min_pix();
        logic [31:0] d;
        do_reset();
        set_rect(0, 10, 20, 5, 7);
        set_rect(1, 0, 14, 3, 3);
        send_frame(1, 0);
        wait_burst();
        check_status("minpix_first");
        drain("minpix_first", m_used);
        mm_write(A_MINPIX, 32'd15);
        mm_read(A_MINPIX, d);
        total++; if (d !== 32'd15) begin bad++; $display("FAIL minpix_rw: got %h expected f", d); end
        for (int f = 0; f < MSG_INTERVAL; f++) begin
            send_frame(1, 0);
            wait_burst();
        end
        check_status("minpix_second");
        drain("minpix_second", m_used);
    endtask

    task automatic test_interval();
        logic [31:0] d;
        logic [11:0] burst_mask;
        int x0, y0;
        do_reset();
        mm_write(A_CHEN, 32'hB);
        mm_read(A_CHEN, d);
        total++; if (d !== 32'hB) begin bad++; $display("FAIL ch_en_rw: got %h expected b", d); end
        set_rect(0, 10, 20, 5, 7);
        set_rect(2, 0, 31, 0, 9);
        burst_mask = '0;
        for (int f = 0; f < 12; f++) begin
            x0 = $urandom_range(0, 20);
            y0 = $urandom_range(0, 6);
            set_rect(3, x0, x0 + $urandom_range(0, 10), y0, y0 + $urandom_range(0, 3));
            send_frame(1, 0);
            wait_burst();
            mm_read(A_STATUS, d);
            if (d[23:8] != 16'h0) burst_mask[f] = 1'b1;
            check_status("interval");
            drain("interval", m_used);
        end
        total++; if (burst_mask !== 12'h041) begin bad++; $display("FAIL interval_bursts: got %h expected 041", burst_mask); end
    endtask

    task automatic test_fifo_full();
        do_reset();
        set_rect(0, 10, 20, 5, 7);
        set_rect(1, 0, 15, 0, 0);
        set_rect(2, 2, 5, 2, 9);
        set_rect(3, 24, 31, 8, 9);
        for (int f = 0; f < 8; f++) begin
            send_frame(1, 0);
            total++; if (last_fd !== 1'b1) begin bad++; $display("FAIL full_frame_done%0d: got %b expected 1", f, last_fd); end
            wait_burst();
        end
        check_status("full_blocked");
        drain("full_partial", 10);
        check_status("full_after_pop");
        send_frame(1, 0);
        wait_burst();
        check_status("full_resumed");
        drain("full_resumed", m_used);
    endtask

    task automatic test_nonvideo();
        int fd0;
        do_reset();
        set_rect(0, 10, 20, 5, 7);
        fd0 = fd_count;
        send_frame(0, 1);
        wait_burst();
        total++; if (fd_count !== fd0) begin bad++; $display("FAIL nonvideo_pulse: got %0d expected %0d", fd_count, fd0); end
        check_status("nonvideo");
        send_frame(1, 0);
        wait_burst();
        check_status("nonvideo_next");
        drain("nonvideo_next", m_used);
    endtask

    task automatic test_flush_and_read();
        logic [31:0] d, e;
        do_reset();
        set_rect(0, 10, 20, 5, 7);
        set_rect(1, 0, 15, 0, 0);
        set_rect(2, 2, 5, 2, 9);
        set_rect(3, 24, 31, 8, 9);
        send_frame(1, 0);
        tick(4);
        mm_read(A_STATUS, d);
        total++; if (d[0] !== 1'b1) begin bad++; $display("FAIL flush_busy_before: got %b expected 1", d[0]); end
        mm_write(A_STATUS, 32'h10);
        exp_q.delete(); m_used = 0;
        check_status("flush_after");
        total++; if (msg_pending !== 1'b0) begin bad++; $display("FAIL flush_pending: got %b expected 0", msg_pending); end
        wait_burst();
        check_status("flush_settled");

        do_reset();
        set_rect(0, 10, 20, 5, 7);
        send_frame(1, 0);
        wait_burst();
        check_status("dblread_before");
        @(negedge clk);
        s_chipselect = 1; s_read = 1; s_address = A_MSG;
        @(negedge clk);
        d = s_readdata;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'h0;
        m_used--;
        total++; if (d !== e) begin bad++; $display("FAIL dblread_word: got %h expected %h", d, e); end
        @(negedge clk);
        s_chipselect = 0; s_read = 0;
        check_status("dblread_after");
        drain("dblread_rest", m_used);
        drain("empty_read", 1);
        check_status("dblread_empty");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_min_pix();
        test_interval();
        test_fifo_full();
        test_nonvideo();
        test_flush_and_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
